// File: rtl/corescore_pkg.sv
// Shared definitions for the corescore reset sequencer: state encodings and
// small elaboration-time helpers.
package corescore_pkg;

  localparam logic [1:0] ST_RESET   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_STAGGER = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_RESET   = ST_RESET,
    S_HOLD    = ST_HOLD,
    S_STAGGER = ST_STAGGER,
    S_DONE    = ST_DONE
  } rst_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/corescore_rst_seq_timer.sv
// Loadable down-counter with a terminal-count (zero) flag; shared by the
// hold and stagger phases of the reset sequencer.
module corescore_rst_seq_timer
  import corescore_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  // NOTE: the declaration initializer matches the reset value so the register
  // powers up in a known state before the first reset edge arrives.
  logic [W-1:0] count_q = '0;
  logic [W-1:0] count_d;

  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/corescore_rst_seq.sv
// Reset sequencer: releases the interconnect reset after a hold period, then
// releases core reset groups one at a time, and finally raises o_ready.
module corescore_rst_seq
  import corescore_pkg::*;
#(
  parameter int GROUPS         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_rst_ic,
  output logic [GROUPS-1:0] o_rst_cores,
  output logic              o_ready
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int IW = $clog2(GROUPS + 1);

  // The timer holds "edges remaining after this one"; edge 1 is consumed by
  // the RESET->HOLD transition itself, hence HOLD_CYCLES-2.
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
  localparam logic [CW-1:0] STAG_LOAD = CW'(STAGGER_CYCLES - 1);

  rst_state_e        state_q     = S_RESET;
  rst_state_e        state_d;
  logic              rst_ic_q    = 1'b1;
  logic              rst_ic_d;
  logic [GROUPS-1:0] rst_cores_q = {GROUPS{1'b1}};
  logic [GROUPS-1:0] rst_cores_d;
  logic              ready_q     = 1'b0;
  logic              ready_d;
  logic [IW-1:0]     idx_q       = '0;
  logic [IW-1:0]     idx_d;

  logic              tmr_load;
  logic [CW-1:0]     tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  corescore_rst_seq_timer #(
    .W (CW)
  ) u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    rst_ic_d    = rst_ic_q;
    rst_cores_d = rst_cores_q;
    ready_d     = ready_q;
    idx_d       = idx_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    if (i_rst) begin
      state_d     = S_RESET;
      rst_ic_d    = 1'b1;
      rst_cores_d = {GROUPS{1'b1}};
      ready_d     = 1'b0;
      idx_d       = '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          // A one-edge hold releases the interconnect on edge 1 itself.
          if (HOLD_CYCLES == 1) begin
            rst_ic_d = 1'b0;
            state_d  = S_STAGGER;
            tmr_load = 1'b1;
            tmr_val  = STAG_LOAD;
          end else begin
            state_d  = S_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end

        S_HOLD: begin
          if (tmr_zero) begin
            rst_ic_d = 1'b0;
            state_d  = S_STAGGER;
            tmr_load = 1'b1;
            tmr_val  = STAG_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end

        S_STAGGER: begin
          if (tmr_zero) begin
            if (idx_q == IW'(GROUPS)) begin
              ready_d = 1'b0 | 1'b1;
              state_d = S_DONE;
            end else begin
              for (int k = 0; k < GROUPS; k++) begin
                if (idx_q == IW'(k)) rst_cores_d[k] = 1'b0;
              end
              idx_d    = idx_q + IW'(1);
              tmr_load = 1'b1;
              // After the last group, o_ready follows one edge later.
              tmr_val  = (idx_q == IW'(GROUPS - 1)) ? '0 : STAG_LOAD;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_RESET;
      rst_ic_q    <= 1'b1;
      rst_cores_q <= {GROUPS{1'b1}};
      ready_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      rst_ic_q    <= rst_ic_d;
      rst_cores_q <= rst_cores_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
    end
  end

  assign o_rst_ic    = rst_ic_q;
  assign o_rst_cores = rst_cores_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_corescore_rst_seq.sv
// Scoreboard bench for corescore_rst_seq: three instances (default, minimal
// 1/1/1, and 32 groups) share one reset; expected output changes are queued.
module tb_corescore_rst_seq;

  localparam int INF = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ic0, rdy0;
  logic [3:0]  cores0;
  logic        ic1, rdy1;
  logic [0:0]  cores1;
  logic        ic2, rdy2;
  logic [31:0] cores2;

  corescore_rst_seq #(.GROUPS(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .o_rst_ic(ic0), .o_rst_cores(cores0), .o_ready(rdy0));
  corescore_rst_seq #(.GROUPS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .o_rst_ic(ic1), .o_rst_cores(cores1), .o_ready(rdy1));
  corescore_rst_seq #(.GROUPS(32), .HOLD_CYCLES(16), .STAGGER_CYCLES(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .o_rst_ic(ic2), .o_rst_cores(cores2), .o_ready(rdy2));

  int g_p [3] = '{4, 1, 32};
  int h_p [3] = '{16, 1, 16};
  int s_p [3] = '{8, 1, 8};

  // Packed view of one instance's outputs: {ic, cores[31:0], ready}.
  typedef struct {
    int          cyc;
    logic [33:0] val;
  } ev_t;

  ev_t         q0[$], q1[$], q2[$];
  logic [33:0] exp_cur [3];
  logic [33:0] last    [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [33:0] rst_val(input int d);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < g_p[d]; k++) m[k] = 1'b1;
    return {1'b1, m, 1'b0};
  endfunction

  function automatic logic [33:0] outs(input int d);
    case (d)
      0:       return {ic0, 28'd0, cores0, rdy0};
      1:       return {ic1, 31'd0, cores1, rdy1};
      default: return {ic2, cores2, rdy2};
    endcase
  endfunction

  function automatic bit order_ok(input logic [33:0] v, input int g);
    bit ok;
    ok = 1'b1;
    if (v[0] && v[33]) ok = 1'b0;
    for (int k = 0; k < g; k++) begin
      if (!v[k+1] && v[33]) ok = 1'b0;
      if (k > 0 && !v[k+1] && v[k]) ok = 1'b0;
      if (v[0] && v[k+1]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic push_ev(input int d, input int c, input logic [33:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    exp_cur[d] = v;
  endtask

  // Queue every release that lands before edge eh (absolute), then the
  // reassertion at eh if anything had been released. e1 is absolute edge 1.
  task automatic push_segment(input int e1, input int eh);
    for (int d = 0; d < 3; d++) begin
      logic [33:0] v;
      int          a;
      v = exp_cur[d];
      a = e1 + h_p[d] - 1;
      if (a < eh) begin v[33] = 1'b0; push_ev(d, a, v); end
      for (int k = 0; k < g_p[d]; k++) begin
        a = e1 + h_p[d] + (k + 1) * s_p[d] - 1;
        if (a < eh) begin v[k+1] = 1'b0; push_ev(d, a, v); end
      end
      a = e1 + h_p[d] + g_p[d] * s_p[d];
      if (a < eh) begin v[0] = 1'b1; push_ev(d, a, v); end
      if (eh < INF && exp_cur[d] != rst_val(d)) push_ev(d, eh, rst_val(d));
    end
  endtask

  task automatic observe(input int d);
    logic [33:0] now;
    ev_t         e;
    bit          have;
    now  = outs(d);
    assert (order_ok(now, g_p[d])) else begin
      errors++;
      $display("FAIL dut%0d_order: got %0h at cycle %0d", d, now, cyc);
    end
    if (now !== last[d]) begin
      have = 1'b1;
      case (d)
        0:       if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
        1:       if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
        default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
      endcase
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected: got %0h at cycle %0d, nothing expected", d, now, cyc);
      end else begin
        check($sformatf("dut%0d_edge", d), 64'(cyc), 64'(e.cyc));
        check($sformatf("dut%0d_value", d), 64'(now), 64'(e.val));
      end
      last[d] = now;
    end
  endtask

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) observe(d);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Hold rst low until the negedge before edge eh, pulse high for one edge,
  // and return the new absolute edge 1.
  task automatic pulse_at(input int eh, output int e1);
    wait_cyc(eh - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e1 = cyc + 1;
  endtask

  initial begin
    int e1;
    int eh;
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_cur[d] = rst_val(d);
      last[d]    = rst_val(d);
      check($sformatf("dut%0d_initial", d), 64'(outs(d)), 64'(rst_val(d)));
    end
    mon_en = 1'b1;

    // i_rst high for three edges, then low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e1  = cyc + 1;
    // Pulse at relative edge 30 (mid-stagger for the default instance).
    eh  = e1 + 29;
    push_segment(e1, eh);
    pulse_at(eh, e1);
    // Pulse at relative edge 10 (inside hold).
    eh = e1 + 9;
    push_segment(e1, eh);
    pulse_at(eh, e1);
    // Full run to DONE for every instance, then a single-cycle pulse.
    eh = e1 + 299;
    push_segment(e1, eh);
    pulse_at(eh, e1);
    // Full rerun after the DONE pulse.
    push_segment(e1, INF);
    wait_cyc(e1 + 300);
    @(negedge clk);

    check("dut0_pending", 64'(q0.size()), 64'd0);
    check("dut1_pending", 64'(q1.size()), 64'd0);
    check("dut2_pending", 64'(q2.size()), 64'd0);
    check("dut0_final_ready", 64'(rdy0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/corescore_rst_seq.md
CORESCORE_RST_SEQ -- requirements
Module: corescore_rst_seq

Interface
REQ-001 Parameter GROUPS, default 4; number of independently released core reset groups, legal range 1..32.
REQ-002 Parameter HOLD_CYCLES, default 16; consecutive i_rst-low cycles before interconnect release, legal value >=1.
REQ-003 Parameter STAGGER_CYCLES, default 8; cycles between successive releases, legal value >=1.
REQ-004 i_clk  input  1  single clock, driven by the board clock generator output; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high, driven by the clock generator's registered reset output.
REQ-006 o_rst_ic  output  1  active-high reset for the interconnect and UART collector.
REQ-007 o_rst_cores  output  GROUPS  active-high per-group core resets; bit 0 releases first.
REQ-008 o_ready  output  1  high once every reset is released.

Function
REQ-009 All outputs SHALL be registered; no combinational path from i_rst to any output.
REQ-010 States SHALL be RESET, HOLD, STAGGER and DONE.
REQ-011 Edge numbering: edge 1 is the first rising edge sampling i_rst low after any edge sampling it high.
REQ-012 HOLD SHALL count i_rst-low edges; o_rst_ic SHALL read low after edge HOLD_CYCLES, and the FSM SHALL enter STAGGER.
REQ-013 o_rst_cores[k] SHALL read low after edge HOLD_CYCLES + (k+1)*STAGGER_CYCLES, for k = 0..GROUPS-1.
REQ-014 o_ready SHALL read high after edge HOLD_CYCLES + GROUPS*STAGGER_CYCLES + 1, and the FSM SHALL enter DONE.
REQ-015 Once deasserted, a reset output SHALL stay low until i_rst is sampled high; release order is strictly o_rst_ic, then bit 0 upward.
REQ-016 i_rst sampled high in any state SHALL, after that edge, drive o_rst_ic=1, o_rst_cores all 1 and o_ready=0; the counter and group index SHALL clear and the FSM SHALL go to RESET.
REQ-017 The sequence restarts from edge 1 on the next i_rst-low sample; no partial progress SHALL be retained.
REQ-018 A single-cycle i_rst pulse in DONE SHALL cause a full re-sequence.
REQ-019 The counter width SHALL be $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1); no counter wrap SHALL occur in any state.
REQ-020 DONE SHALL be terminal while i_rst is low; the counter SHALL be idle in RESET and DONE.

Reset
REQ-021 Reset values: o_rst_ic=1, o_rst_cores={GROUPS{1'b1}}, o_ready=0, state=RESET, counter=0, group index=0.
REQ-022 Register initial values SHALL equal their reset values, so outputs are held in reset before the first i_rst edge.

Structure
REQ-023 The state encoding localparams SHALL reside in the shared package corescore_pkg.
REQ-024 One sub-module, corescore_rst_seq_timer, is natural: it is a loadable down-counter with a terminal-count flag, shared by HOLD and STAGGER.
REQ-025 There SHALL be no clock gating or second clock domain.

Verification (defaults GROUPS=4, HOLD=16, STAGGER=8)
REQ-026 Stimulus: i_rst high for 3 cycles, then low. Response: o_rst_ic low after edge 16; cores low after edges 24, 32, 40 and 48; o_ready high after edge 49.
REQ-027 Stimulus: i_rst pulsed high for 1 cycle at edge 30, i.e. mid-STAGGER. Response: after that edge, o_rst_ic=1, o_rst_cores=4'b1111 and o_ready=0; the release times of REQ-026 then repeat relative to the new edge 1.
REQ-028 Stimulus: i_rst pulsed high for 1 cycle at edge 10, i.e. in HOLD. Response: o_rst_ic never deasserts before 16 fresh low edges.
REQ-029 Stimulus: i_rst pulsed for 1 cycle in DONE. Response: all resets reassert and the full sequence reruns; o_ready returns high 49 edges later.
REQ-030 Parameter sweep over GROUPS=1 with HOLD=1, STAGGER=1 and over GROUPS=32. Response: release edges match REQ-012 to REQ-014 exactly (1/2/3 and 16/.../272/273); an assertion confirms the release order never inverts.
